// File: rtl/orcs_pkg.sv
// Shared definitions for the ORCS control path.
// Opcodes, ALU control encodings, FSM states and instruction fields.
package orcs_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_BZ   = 4'h5;
    localparam logic [3:0] OP_BN   = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;
    localparam int ALU_UPD_BIT = 2;

    // Bit positions within alu_status
    localparam int STAT_ZERO = 1;
    localparam int STAT_NEG  = 0;

    // Instruction field positions
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 0;
    localparam int TGT_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic [3:0] f_opc(input logic [15:0] ins);
        return ins[OPC_LSB +: 4];
    endfunction

    function automatic logic [3:0] f_rd(input logic [15:0] ins);
        return ins[RD_LSB +: 4];
    endfunction

    function automatic logic [3:0] f_ra(input logic [15:0] ins);
        return ins[RA_LSB +: 4];
    endfunction

    function automatic logic [3:0] f_rb(input logic [15:0] ins);
        return ins[RB_LSB +: 4];
    endfunction

    function automatic logic [TGT_W-1:0] f_tgt(input logic [15:0] ins);
        return ins[TGT_W-1:0];
    endfunction

    // ALU control word for an opcode; upper bit requests a status update
    function automatic logic [2:0] alu_ctrl_of(input logic [3:0] op);
        logic [2:0] c;
        c = {1'b0, ALU_NONE};
        case (op)
            OP_ADD:  c = {1'b1, ALU_ADD};
            OP_SUB:  c = {1'b1, ALU_SUB};
            OP_MOV:  c = {1'b0, ALU_PASS};
            OP_CMP:  c = {1'b1, ALU_SUB};
            default: c = {1'b0, ALU_NONE};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit: fetch, decode, execute, write-back.
// Drives register-file addresses and the ALU control word.
module alu_sequencer
    import orcs_pkg::*;
#(
    parameter int PC_WIDTH      = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  instr_req,
    output logic [PC_WIDTH-1:0]   instr_addr,
    input  logic                  instr_valid,
    input  logic [15:0]           instr_data,
    output logic [3:0]            rf_raddr_a,
    output logic [3:0]            rf_raddr_b,
    output logic [2:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [1:0]            alu_status,
    output logic                  rf_we,
    output logic [3:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy,
    output logic                  halted,
    output logic                  fault
);

    localparam int CW = $clog2(FETCH_TIMEOUT + 1);

    state_t                state;
    state_t                next_state;
    logic [PC_WIDTH-1:0]   pc;
    logic [15:0]           ir;
    logic [DATA_WIDTH-1:0] result;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;
    logic                  timeout;
    logic                  fault_q;
    logic [3:0]            opc;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   tgt;

    assign opc     = f_opc(ir);
    assign pc_inc  = pc + 1'b1;
    assign tgt     = PC_WIDTH'(f_tgt(ir));
    assign cnt_inc = cnt + 1'b1;
    assign timeout = (cnt_inc == CW'(FETCH_TIMEOUT));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (start) next_state = S_FETCH;
            end
            S_FETCH: begin
                if (instr_valid)  next_state = S_DECODE;
                else if (timeout) next_state = S_HALT;
            end
            S_DECODE: begin
                next_state = S_EXEC;
            end
            S_EXEC: begin
                case (opc)
                    OP_ADD, OP_SUB, OP_MOV:      next_state = S_WB;
                    OP_NOP, OP_CMP, OP_BZ, OP_BN: next_state = S_FETCH;
                    default:                     next_state = S_HALT;
                endcase
            end
            S_WB: begin
                next_state = S_FETCH;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Program counter, instruction/result registers, timeout and fault
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            result  <= '0;
            cnt     <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc  <= '0;
                        cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        ir  <= instr_data;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout) fault_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    result <= alu_result;
                    case (opc)
                        OP_NOP, OP_CMP: pc <= pc_inc;
                        OP_BZ: pc <= alu_status[STAT_ZERO] ? tgt : pc_inc;
                        OP_BN: pc <= alu_status[STAT_NEG] ? tgt : pc_inc;
                        OP_ADD, OP_SUB, OP_MOV, OP_HALT: ;
                        default: fault_q <= 1'b1;
                    endcase
                end
                S_WB: begin
                    pc <= pc_inc;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        instr_req  = 1'b0;
        rf_raddr_a = 4'd0;
        rf_raddr_b = 4'd0;
        alu_ctrl   = 3'b000;
        rf_we      = 1'b0;
        rf_waddr   = 4'd0;
        rf_wdata   = '0;
        busy       = 1'b1;
        halted     = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_FETCH: begin
                instr_req = 1'b1;
            end
            S_DECODE: begin
                rf_raddr_a = f_ra(ir);
                rf_raddr_b = f_rb(ir);
            end
            S_EXEC: begin
                rf_raddr_a = f_ra(ir);
                rf_raddr_b = f_rb(ir);
                alu_ctrl   = alu_ctrl_of(opc);
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = f_rd(ir);
                rf_wdata = result;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign instr_addr = pc;
    assign fault      = fault_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ALU, register file and instruction memory
// models around the DUT, checked against an instruction-level model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [2:0]  alu_ctrl;
    logic [15:0] alu_result;
    logic [1:0]  alu_status;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        busy;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .PC_WIDTH(8),
        .DATA_WIDTH(16),
        .FETCH_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .instr_req(instr_req),
        .instr_addr(instr_addr),
        .instr_valid(instr_valid),
        .instr_data(instr_data),
        .rf_raddr_a(rf_raddr_a),
        .rf_raddr_b(rf_raddr_b),
        .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .alu_status(alu_status),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .busy(busy),
        .halted(halted),
        .fault(fault)
    );

    // Instruction memory with optional random wait states
    logic [15:0] imem [256];
    bit          mem_en;
    int          max_wait;
    int          wait_left;

    assign instr_valid = instr_req && mem_en && (wait_left == 0);
    assign instr_data  = imem[instr_addr];

    always @(posedge clk or posedge reset) begin
        if (reset) wait_left <= 0;
        else if (instr_req && mem_en) begin
            if (wait_left > 0) wait_left <= wait_left - 1;
            else wait_left <= $urandom_range(max_wait, 0);
        end
    end

    // Register file: registered reads, write on rf_we
    logic [15:0] regs [16];
    logic [15:0] rd_a;
    logic [15:0] rd_b;

    always @(posedge clk) begin
        rd_a <= regs[rf_raddr_a];
        rd_b <= regs[rf_raddr_b];
        if (rf_we) regs[rf_waddr] <= rf_wdata;
    end

    // ALU with registered {zero, negative} flags
    always_comb begin
        alu_result = 16'h0;
        case (alu_ctrl[1:0])
            2'b01:   alu_result = rd_a + rd_b;
            2'b10:   alu_result = rd_a - rd_b;
            2'b11:   alu_result = rd_a;
            default: alu_result = 16'h0;
        endcase
    end

    always @(posedge clk or posedge reset) begin
        if (reset) alu_status <= 2'b00;
        else if (alu_ctrl[2])
            alu_status <= {alu_result == 16'h0, alu_result[15]};
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op,
        input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
        return {op, rd, ra, rb};
    endfunction

    // Instruction-level reference model
    logic [15:0] rinit [16];
    logic [19:0] exp_w[$];
    logic [19:0] obs_w[$];
    logic [7:0]  exp_f[$];
    logic [7:0]  obs_f[$];
    logic [7:0]  exp_pc;
    logic        exp_fault;
    int          exp_cycles;

    task automatic run_model();
        logic [15:0] r [16];
        logic [7:0]  pc;
        logic        z;
        logic        n;
        logic [15:0] ins;
        logic [15:0] v;
        bit          done;
        exp_w.delete();
        exp_f.delete();
        for (int i = 0; i < 16; i++) r[i] = rinit[i];
        pc = 8'h00;
        z = 1'b0;
        n = 1'b0;
        exp_fault = 1'b0;
        exp_cycles = 0;
        done = 0;
        for (int s = 0; s < 300 && !done; s++) begin
            exp_f.push_back(pc);
            ins = imem[pc];
            case (ins[15:12])
                4'h1, 4'h2, 4'h3: begin
                    if (ins[15:12] == 4'h1) v = r[ins[7:4]] + r[ins[3:0]];
                    else if (ins[15:12] == 4'h2) v = r[ins[7:4]] - r[ins[3:0]];
                    else v = r[ins[7:4]];
                    if (ins[15:12] != 4'h3) begin
                        z = (v == 16'h0);
                        n = v[15];
                    end
                    r[ins[11:8]] = v;
                    exp_w.push_back({ins[11:8], v});
                    pc = pc + 8'd1;
                    exp_cycles += 4;
                end
                4'h4: begin
                    v = r[ins[7:4]] - r[ins[3:0]];
                    z = (v == 16'h0);
                    n = v[15];
                    pc = pc + 8'd1;
                    exp_cycles += 3;
                end
                4'h0: begin
                    pc = pc + 8'd1;
                    exp_cycles += 3;
                end
                4'h5: begin
                    pc = z ? ins[7:0] : pc + 8'd1;
                    exp_cycles += 3;
                end
                4'h6: begin
                    pc = n ? ins[7:0] : pc + 8'd1;
                    exp_cycles += 3;
                end
                4'hF: begin
                    exp_cycles += 3;
                    done = 1;
                end
                default: begin
                    exp_fault = 1'b1;
                    exp_cycles += 3;
                    done = 1;
                end
            endcase
        end
        exp_pc = pc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    // Run the loaded program and compare against the model
    task automatic run_prog(input string tag, input int waits);
        int busy_cnt;
        int stray;
        int k;
        do_reset();
        max_wait = waits;
        mem_en = 1'b1;
        for (int i = 0; i < 16; i++) regs[i] = rinit[i];
        run_model();
        obs_w.delete();
        obs_f.delete();
        busy_cnt = 0;
        stray = 0;
        pulse_start();
        for (k = 0; k < 3000; k++) begin
            if (halted) break;
            if (rf_we) obs_w.push_back({rf_waddr, rf_wdata});
            if (instr_req && instr_valid) obs_f.push_back(instr_addr);
            if (busy) busy_cnt++;
            if (alu_ctrl != 3'b000 && (instr_req || rf_we)) stray++;
            @(negedge clk);
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
        check({tag, "_pc"}, 32'(instr_addr), 32'(exp_pc));
        check({tag, "_stray_alu"}, 32'(stray), 32'd0);
        check({tag, "_nwr"}, 32'(obs_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
            check({tag, "_wr"}, 32'(obs_w[i]), 32'(exp_w[i]));
        check({tag, "_nfetch"}, 32'(obs_f.size()), 32'(exp_f.size()));
        for (int i = 0; i < obs_f.size() && i < exp_f.size(); i++)
            check({tag, "_fetch"}, 32'(obs_f[i]), 32'(exp_f[i]));
        if (waits == 0)
            check({tag, "_cycles"}, 32'(busy_cnt), 32'(exp_cycles));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mem_en = 1'b0;
        max_wait = 0;
        fill_halt();
        for (int i = 0; i < 16; i++) begin
            regs[i] = 16'h0;
            rinit[i] = 16'h0;
        end
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_req", 32'(instr_req), 32'd0);
        check("rst_addr", 32'(instr_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_alu", 32'(alu_ctrl), 32'd0);
        check("rst_we", 32'(rf_we), 32'd0);
        reset = 1'b0;

        // ADD r3 = r1 + r2, cycle by cycle
        fill_halt();
        imem[0] = enc(4'h1, 4'd3, 4'd1, 4'd2);
        for (int i = 0; i < 16; i++) regs[i] = 16'h0;
        regs[1] = 16'd5;
        regs[2] = 16'd7;
        mem_en = 1'b1;
        max_wait = 0;
        pulse_start();
        for (int c = 1; c <= 4; c++) begin
            check("add_req", 32'(instr_req), 32'(c == 1));
            check("add_alu", 32'(alu_ctrl), (c == 3) ? 32'd5 : 32'd0);
            check("add_we", 32'(rf_we), 32'(c == 4));
            if (c == 4) begin
                check("add_waddr", 32'(rf_waddr), 32'd3);
                check("add_wdata", 32'(rf_wdata), 32'd12);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 20 && !halted; k++) @(negedge clk);
        check("add_halted", 32'(halted), 32'd1);
        check("add_pc", 32'(instr_addr), 32'd1);
        pulse_start();
        check("halt_start_ign", 32'(halted), 32'd1);
        check("halt_start_req", 32'(instr_req), 32'd0);

        // CMP r1,r1 then BZ 0x20
        fill_halt();
        for (int i = 0; i < 16; i++) rinit[i] = 16'h0;
        rinit[1] = 16'd9;
        imem[0] = enc(4'h4, 4'd0, 4'd1, 4'd1);
        imem[1] = 16'h5020;
        run_prog("cmp_bz", 0);
        check("cmp_status", 32'(alu_status), 32'd2);
        check("cmp_pc", 32'(instr_addr), 32'h20);

        // SUB 3-5, BN 0x40 taken, BZ at 0x40 not taken
        fill_halt();
        rinit[1] = 16'd3;
        rinit[2] = 16'd5;
        imem[0] = enc(4'h2, 4'd4, 4'd1, 4'd2);
        imem[1] = 16'h6040;
        imem[8'h40] = 16'h5050;
        run_prog("sub_bn", 0);
        check("sub_pc", 32'(instr_addr), 32'h41);
        check("sub_r4", 32'(regs[4]), 32'hFFFE);

        // pc wraps 0xFF -> 0x00
        fill_halt();
        for (int i = 0; i < 16; i++) rinit[i] = 16'h0;
        rinit[1] = 16'd3;
        imem[0] = 16'h6010;
        imem[1] = enc(4'h4, 4'd0, 4'd0, 4'd0);
        imem[2] = 16'h50FE;
        imem[8'hFE] = enc(4'h2, 4'd9, 4'd0, 4'd1);
        imem[8'hFF] = 16'h0000;
        run_prog("wrap", 0);
        check("wrap_pc", 32'(instr_addr), 32'h10);

        // Illegal opcode
        fill_halt();
        imem[0] = 16'h9123;
        run_prog("illegal", 0);

        // Fetch timeout
        do_reset();
        mem_en = 1'b0;
        pulse_start();
        for (int c = 1; c <= 15; c++) begin
            if (c == 15) begin
                check("to_req15", 32'(instr_req), 32'd1);
                check("to_halt15", 32'(halted), 32'd0);
            end
            @(negedge clk);
        end
        check("to_halted", 32'(halted), 32'd1);
        check("to_fault", 32'(fault), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        mem_en = 1'b1;
        pulse_start();
        @(negedge clk);
        check("to_start_ign", 32'(halted), 32'd1);
        check("to_start_req", 32'(instr_req), 32'd0);

        // Reset during WRITEBACK
        do_reset();
        fill_halt();
        imem[0] = enc(4'h1, 4'd3, 4'd1, 4'd2);
        mem_en = 1'b1;
        max_wait = 0;
        pulse_start();
        for (int k = 0; k < 20 && !rf_we; k++) @(negedge clk);
        check("wbr_seen", 32'(rf_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("wbr_we", 32'(rf_we), 32'd0);
        check("wbr_busy", 32'(busy), 32'd0);
        check("wbr_pc", 32'(instr_addr), 32'd0);
        check("wbr_req", 32'(instr_req), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("wbr_idle", 32'(busy), 32'd0);

        // Random forward-branching programs
        for (int t = 0; t < 10; t++) begin
            int np;
            logic [3:0] op;
            int r;
            fill_halt();
            np = $urandom_range(12, 4);
            for (int i = 0; i < 16; i++)
                rinit[i] = (i % 2 == 0) ? 16'($urandom_range(3, 0))
                                        : 16'($urandom);
            for (int i = 0; i < np; i++) begin
                r = $urandom_range(31, 0);
                op = (r < 28) ? 4'(r % 7) : 4'(r - 21);
                if (op == 4'h5 || op == 4'h6)
                    imem[i] = {op, 8'($urandom_range(np, i + 1))};
                else
                    imem[i] = {op, 4'($urandom), 4'($urandom), 4'($urandom)};
            end
            run_prog("rand", (t % 2 == 0) ? 0 : 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control unit for the ORCS processor datapath.
- Fetches 16-bit instructions, decodes them, and drives register-file read/write addresses and the 3-bit ALU control word.
- Sequences ALU results into write-back and takes conditional branches on the ALU status flags {zero, negative}.
- Sits between instruction memory, the register file and the ALU; ALU operands A/B are wired from register-file read data outside this block.

Parameters:
- PC_WIDTH, 8, program counter width; wraps modulo 2^PC_WIDTH.
- DATA_WIDTH, 16, ALU result and register data width.
- FETCH_TIMEOUT, 15, maximum wait cycles for instr_valid before fault.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: leave IDLE and begin fetching at pc=0.
- instr_req  out  1  fetch request; held high until instr_valid.
- instr_addr  out  PC_WIDTH  fetch address, equals pc.
- instr_valid  in  1  instr_data valid this cycle.
- instr_data  in  16  [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb / [7:0] branch target.
- rf_raddr_a  out  4  register-file port A address.
- rf_raddr_b  out  4  register-file port B address (1-cycle registered read).
- alu_ctrl  out  3  [2] = update status, [1:0] = 01 add, 10 sub, 11 pass A.
- alu_result  in  DATA_WIDTH  combinational ALU output.
- alu_status  in  2  registered ALU flags {zero, negative}.
- rf_we  out  1  register write enable.
- rf_waddr  out  4  write address.
- rf_wdata  out  DATA_WIDTH  write data.
- busy  out  1  high in any state other than IDLE or HALTED.
- halted  out  1  high in HALTED.
- fault  out  1  sticky; set on fetch timeout or illegal opcode.

Behaviour:
- Reset values: state=IDLE, pc=0, instr register=0, result register=0, timeout counter=0, all outputs 0, alu_ctrl=3'b000.
- IDLE: on start -> FETCH with pc=0. start is ignored in all other states.
- FETCH:
  - instr_req=1, instr_addr=pc.
  - On instr_valid: latch instr_data, clear the counter, go to DECODE.
  - Otherwise increment the counter. When the counter reaches FETCH_TIMEOUT with no valid, set fault and go to HALTED.
- DECODE: rf_raddr_a=ra, rf_raddr_b=rb, held through EXECUTE; go to EXECUTE.
- EXECUTE (one cycle), alu_ctrl by opcode:
  - ADD 0x1 -> 101.
  - SUB 0x2 -> 110.
  - MOV 0x3 -> 011.
  - CMP 0x4 -> 110.
  - Otherwise -> 000.
  - Capture alu_result into the result register at the edge leaving EXECUTE.
  - ADD/SUB/MOV -> WRITEBACK.
  - CMP -> FETCH, pc+1 (status only, no write).
  - NOP 0x0 -> FETCH, pc+1.
  - BZ 0x5: if alu_status[1] then pc=instr[7:0], else pc+1; -> FETCH.
  - BN 0x6: same as BZ, using alu_status[0].
  - HALT 0xF -> HALTED, pc unchanged.
  - Any other opcode: set fault -> HALTED.
- WRITEBACK (one cycle): rf_we=1, rf_waddr=rd, rf_wdata=result register; pc+1; -> FETCH.
- Branches see the status produced by the most recent status-updating instruction (its edge precedes the branch's EXECUTE).
- Latency with zero-wait fetch:
  - ADD/SUB/MOV: 4 cycles.
  - CMP, NOP, branches: 3 cycles.
- pc wraps 0xFF -> 0x00 on increment.
- HALTED: holds until reset; start has no effect.
- Reset mid-operation: immediate return to reset values; no rf_we or instr_req glitch after assertion.
- alu_ctrl is 000 in every state except EXECUTE, so the ALU status register never updates outside EXECUTE.

Decomposition:
- Shared package orcs_pkg:
  - opcode constants (NOP, ADD, SUB, MOV, CMP, BZ, BN, HALT);
  - ALU op encodings (01/10/11) and the status-update bit index;
  - state enumeration;
  - instruction field bit positions.
- No sub-module needed; the timeout counter is inline.
- Bench reuses the existing alu module and a simple register-file model.

Test Plan:
- Reset, start, ADD r3=r1+r2 with r1=5, r2=7, zero-wait fetch -> rf_we on cycle 4, rf_waddr=3, rf_wdata=12, alu_ctrl=101 during EXECUTE only.
- CMP r1,r1 (r1=9), then BZ 0x20 -> no rf_we for CMP; status=10; pc becomes 0x20; next instr_addr=0x20.
- SUB 3-5 then BN 0x40, then BZ 0x50 -> negative set, branch to 0x40; BZ at 0x40 not taken, pc=0x41.
- pc=0xFF with NOP -> next instr_addr=0x00.
- instr_valid withheld for FETCH_TIMEOUT=15 cycles -> fault=1, halted=1, busy=0; later start ignored.
- Opcode 0x9 -> fault=1, halted=1. Separately, reset asserted during WRITEBACK -> rf_we drops asynchronously, state IDLE, pc=0.
